// File: rtl/lsu_mem_align.sv
// Load/store memory-access stage: natural-alignment check, single-outstanding req/ack data-memory
// port, right-aligned zero-filled load return, misalignment and access-timeout reporting.
`timescale 1ns/1ps

module lsu_mem_align #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // execute-stage request
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_type,
  input  logic [DATA_LENGTH-1:0]   req_addr,
  input  logic [DATA_LENGTH-1:0]   req_wdata,
  // data-memory port
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [DATA_LENGTH-1:0]   dmem_addr,
  output logic [DATA_LENGTH/8-1:0] dmem_be,
  output logic [DATA_LENGTH-1:0]   dmem_wdata,
  input  logic                     dmem_ack,
  input  logic [DATA_LENGTH-1:0]   dmem_rdata,
  // results
  output logic                     ld_valid,
  output logic [DATA_LENGTH-1:0]   ld_data,
  output logic [2:0]               ld_type,
  output logic                     done,
  output logic                     misalign,
  output logic                     fault,
  output logic [DATA_LENGTH-1:0]   bad_addr
);

  localparam int unsigned NumBytes = DATA_LENGTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);

  // mem_type encoding (funct3-style)
  localparam logic [2:0] MemB  = 3'b000;
  localparam logic [2:0] MemH  = 3'b001;
  localparam logic [2:0] MemW  = 3'b010;
  localparam logic [2:0] MemBU = 3'b100;
  localparam logic [2:0] MemHU = 3'b101;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   dmem_req_q, dmem_req_d;
  logic                   dmem_we_q, dmem_we_d;
  logic [DATA_LENGTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [NumBytes-1:0]    dmem_be_q, dmem_be_d;
  logic [DATA_LENGTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [2:0]             type_q, type_d;
  logic [DATA_LENGTH-1:0] addr_q, addr_d;
  logic                   ld_valid_q, ld_valid_d;
  logic [DATA_LENGTH-1:0] ld_data_q, ld_data_d;
  logic [2:0]             ld_type_q, ld_type_d;
  logic                   done_q, done_d;
  logic                   misalign_q, misalign_d;
  logic                   fault_q, fault_d;
  logic [DATA_LENGTH-1:0] bad_addr_q, bad_addr_d;

  logic [OffW-1:0]        req_off;
  logic                   req_aligned;
  logic [NumBytes-1:0]    req_be;
  logic [DATA_LENGTH-1:0] req_wdata_rep;
  logic [DATA_LENGTH-1:0] rdata_shifted;
  logic [DATA_LENGTH-1:0] load_data;

  assign req_off = req_addr[OffW-1:0];

  // Request decode: alignment, lane enables and lane-replicated store data
  always_comb begin
    req_aligned   = 1'b1;
    req_be        = {{(NumBytes-1){1'b0}}, 1'b1} << req_off;
    req_wdata_rep = {NumBytes{req_wdata[7:0]}};
    case (req_type)
      MemH, MemHU: begin
        req_aligned   = (req_addr[0] == 1'b0);
        req_be        = {{(NumBytes-2){1'b0}}, 2'b11} << req_off;
        req_wdata_rep = {(NumBytes/2){req_wdata[15:0]}};
      end
      MemW: begin
        req_aligned   = (req_off == '0);
        req_be        = '1;
        req_wdata_rep = req_wdata;
      end
      default: ;
    endcase
  end

  // Load return: shift the addressed lanes down and zero everything above the access size
  assign rdata_shifted = dmem_rdata >> {addr_q[OffW-1:0], 3'b000};

  always_comb begin
    case (type_q)
      MemH, MemHU: load_data = {{(DATA_LENGTH-16){1'b0}}, rdata_shifted[15:0]};
      MemW:        load_data = rdata_shifted;
      default:     load_data = {{(DATA_LENGTH-8){1'b0}}, rdata_shifted[7:0]};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    type_d       = type_q;
    addr_d       = addr_q;
    ld_data_d    = ld_data_q;
    ld_type_d    = ld_type_q;
    bad_addr_d   = bad_addr_q;
    ld_valid_d   = 1'b0;
    done_d       = 1'b0;
    misalign_d   = 1'b0;
    fault_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (!req_aligned) begin
            misalign_d = 1'b1;
            bad_addr_d = req_addr;
          end else begin
            state_d      = StWait;
            cnt_d        = '0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = req_we;
            dmem_addr_d  = {req_addr[DATA_LENGTH-1:OffW], {OffW{1'b0}}};
            dmem_be_d    = req_be;
            dmem_wdata_d = req_we ? req_wdata_rep : '0;
            type_d       = req_type;
            addr_d       = req_addr;
          end
        end
      end
      StWait: begin
        // An ack on the timeout cycle still completes the access normally
        if (dmem_ack) begin
          state_d    = StIdle;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          done_d     = 1'b1;
          if (!dmem_we_q) begin
            ld_valid_d = 1'b1;
            ld_data_d  = load_data;
            ld_type_d  = type_q;
          end
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_CYC)) begin
          state_d    = StIdle;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          fault_d    = 1'b1;
          bad_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      type_q       <= MemW;
      addr_q       <= '0;
      ld_valid_q   <= 1'b0;
      ld_data_q    <= '0;
      ld_type_q    <= MemW;
      done_q       <= 1'b0;
      misalign_q   <= 1'b0;
      fault_q      <= 1'b0;
      bad_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      type_q       <= type_d;
      addr_q       <= addr_d;
      ld_valid_q   <= ld_valid_d;
      ld_data_q    <= ld_data_d;
      ld_type_q    <= ld_type_d;
      done_q       <= done_d;
      misalign_q   <= misalign_d;
      fault_q      <= fault_d;
      bad_addr_q   <= bad_addr_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign ld_valid   = ld_valid_q;
  assign ld_data    = ld_data_q;
  assign ld_type    = ld_type_q;
  assign done       = done_q;
  assign misalign   = misalign_q;
  assign fault      = fault_q;
  assign bad_addr   = bad_addr_q;

endmodule

// File: tb/tb_lsu_mem_align.sv
// Scoreboard bench for lsu_mem_align: byte-level reference model, a memory responder that checks
// the dmem port, and a monitor that checks every done/ld_valid/misalign/fault pulse.
`timescale 1ns/1ps

module tb_lsu_mem_align;

  localparam int unsigned TO = 6;

  localparam logic [2:0] TyB  = 3'b000;
  localparam logic [2:0] TyH  = 3'b001;
  localparam logic [2:0] TyW  = 3'b010;
  localparam logic [2:0] TyBU = 3'b100;
  localparam logic [2:0] TyHU = 3'b101;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        ld_valid, done, misalign, fault;
  logic [31:0] ld_data, bad_addr;
  logic [2:0]  ld_type;

  lsu_mem_align #(
    .DATA_LENGTH(32),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_type    (ld_type),
    .done       (done),
    .misalign   (misalign),
    .fault      (fault),
    .bad_addr   (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned delay;
  } mem_t;

  typedef struct {
    bit          done;
    bit          ld;
    bit          mis;
    bit          flt;
    logic [31:0] ld_data;
    logic [2:0]  ld_type;
    logic [31:0] bad;
    int unsigned acc_cyc;
    int unsigned lat;
  } rsp_t;

  mem_t mq[$];
  rsp_t rq[$];
  int checks = 0;
  int failures = 0;

  // Expected holding values of ld_data/ld_type/bad_addr
  logic [31:0] last_ld  = 32'h0;
  logic [2:0]  last_ty  = TyW;
  logic [31:0] last_bad = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] t);
    case (t)
      TyW:       return 4;
      TyH, TyHU: return 2;
      default:   return 1;
    endcase
  endfunction

  function automatic logic [2:0] pick_type(input int unsigned n);
    case (n % 5)
      0:       return TyB;
      1:       return TyH;
      2:       return TyW;
      3:       return TyBU;
      default: return TyHU;
    endcase
  endfunction

  // Drive one request; expectations come from byte-level rules, not from the DUT
  task automatic issue(input bit we, input logic [2:0] t, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int unsigned delay);
    mem_t m;
    rsp_t r;
    int unsigned sz;
    int unsigned off;
    int unsigned w;
    sz  = size_of(t);
    off = addr % 4;
    w   = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    r.done = 0; r.ld = 0; r.mis = 0; r.flt = 0;
    r.ld_data = 32'h0; r.ld_type = t; r.bad = 32'h0; r.acc_cyc = cyc; r.lat = 0;
    if ((addr % sz) != 0) begin
      r.mis = 1;
      r.bad = addr;
      r.lat = 1;
    end else begin
      m.addr  = addr - off;
      m.we    = we;
      m.rdata = rdata;
      m.delay = delay;
      m.wdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
        m.be[i] = (i >= off) && (i < off + sz);
        if (we) m.wdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
      end
      mq.push_back(m);
      if (delay <= TO) begin
        r.done = 1;
        r.lat  = 2 + delay;
        if (!we) begin
          r.ld = 1;
          for (int j = 0; j < 4; j++)
            if (j < sz) r.ld_data[8*j +: 8] = rdata[8*(off + j) +: 8];
        end
      end else begin
        r.flt = 1;
        r.bad = addr;
        r.lat = 2 + TO;
      end
    end
    rq.push_back(r);
    req_valid = 1'b1;
    req_we    = we;
    req_type  = t;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_dmem_addr"}, dmem_addr, 32'h0);
    chk({tag, "_dmem_be"}, 32'(dmem_be), 32'h0);
    chk({tag, "_dmem_wdata"}, dmem_wdata, 32'h0);
    chk({tag, "_pulses"}, {28'h0, ld_valid, done, misalign, fault}, 32'h0);
    chk({tag, "_ld_data"}, ld_data, 32'h0);
    chk({tag, "_ld_type"}, 32'(ld_type), 32'(TyW));
    chk({tag, "_bad_addr"}, bad_addr, 32'h0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Memory responder: checks the request fields and holds them stable until it acks
  initial begin
    mem_t m;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && dmem_req) begin
        dmem_ack = 1'b0;
        if (mq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_dmem_req addr=%h required=no request", dmem_addr);
        end else begin
          m = mq.pop_front();
          chk("dmem_addr", dmem_addr, m.addr);
          chk("dmem_be", 32'(dmem_be), 32'(m.be));
          chk("dmem_we", 32'(dmem_we), 32'(m.we));
          chk("dmem_wdata", dmem_wdata, m.wdata);
          chk("ready_low_in_wait", 32'(req_ready), 32'd0);
          for (int k = 0; k <= int'(TO) + 4; k++) begin
            if (k == int'(m.delay)) begin
              dmem_ack   = 1'b1;
              dmem_rdata = m.rdata;
            end else begin
              dmem_rdata = $urandom;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            if (!dmem_req) break;
            if (k == int'(m.delay)) begin
              checks++;
              failures++;
              $display("FAIL req_held_after_ack actual=1 required=0");
              break;
            end
            chk("stable_addr", dmem_addr, m.addr);
            chk("stable_be", 32'(dmem_be), 32'(m.be));
            chk("stable_wdata", dmem_wdata, m.wdata);
          end
        end
      end else begin
        // Stray acks while idle must be ignored
        dmem_ack   = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  // Monitor: every result pulse pops one expectation
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && (done || ld_valid || misalign || fault)) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse done=%b ld_valid=%b misalign=%b fault=%b required=none",
                   done, ld_valid, misalign, fault);
        end else begin
          r = rq.pop_front();
          if (r.ld) begin
            last_ld = r.ld_data;
            last_ty = r.ld_type;
          end
          if (r.mis || r.flt) last_bad = r.bad;
          chk("pulse_flags", {28'h0, ld_valid, done, misalign, fault},
              {28'h0, r.ld, r.done, r.mis, r.flt});
          chk("latency", cyc - r.acc_cyc, r.lat);
          chk("ld_data", ld_data, last_ld);
          chk("ld_type", 32'(ld_type), 32'(last_ty));
          chk("bad_addr", bad_addr, last_bad);
          chk("ready_after_pulse", 32'(req_ready), 32'd1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_type  = TyW;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, TyB,  32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0);
    issue(1'b1, TyH,  32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0);
    issue(1'b0, TyW,  32'h0000_3001, 32'h0, 32'h0, 0);
    issue(1'b0, TyHU, 32'h0000_4002, 32'h0, 32'hFEDC_0000, 5);
    issue(1'b0, TyW,  32'h0000_5000, 32'h0, 32'h0, 99);
    issue(1'b0, TyW,  32'h0000_5000, 32'h0, 32'h1357_9BDF, TO);
    issue(1'b1, TyB,  32'h0000_6001, 32'hCAFE_F00D, 32'h0, 1);

    for (int n = 0; n < 300; n++) begin
      logic [2:0]  t;
      logic [31:0] a;
      int unsigned d;
      t = pick_type($urandom);
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      d = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, TO + 2);
      issue($urandom_range(0, 1) == 1, t, a, $urandom, $urandom, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of an access: dmem_req must drop at once, no result for it
    issue(1'b0, TyW, 32'h0000_7000, 32'h0, 32'h0, 99);
    rq.delete(rq.size() - 1);
    @(negedge clk);
    @(negedge clk);
    chk("req_before_reset", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_req", 32'(dmem_req), 32'd0);
    last_ld  = 32'h0;
    last_ty  = TyW;
    last_bad = 32'h0;
    check_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TO + 4) @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    issue(1'b0, TyH, 32'h0000_8006, 32'h0, 32'hBEEF_1234, 2);

    w = 0;
    while ((rq.size() != 0 || mq.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk("rsp_queue_drained", rq.size(), 32'd0);
    chk("mem_queue_drained", mq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_align.md
Name: lsu_mem_align

Overview:
- Memory-access stage placed directly upstream of the load-data sign/zero-extension stage.
- Accepts one load/store request at a time from the execute stage and checks natural alignment.
- Drives a single-outstanding req/ack data-memory port with word address, byte enables and replicated store data.
- Returns load data right-aligned and zero-filled, together with its mem_type, so the extension stage can sign- or zero-extend it; also flags misalignment and access timeout.

Parameters:
- DATA_LENGTH, 32, data/address width; byte lanes = DATA_LENGTH/8 = 4.
- TIMEOUT_CYC, 255, cycles waiting for dmem_ack before access fault; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  mem_type  access size: B, H, W, BU or HU.
- req_addr  in  DATA_LENGTH  byte address.
- req_wdata  in  DATA_LENGTH  store data, right-aligned.
- dmem_req  out  1  memory request; held until ack.
- dmem_we  out  1  write strobe.
- dmem_addr  out  DATA_LENGTH  word address; {req_addr[31:2], 2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  DATA_LENGTH  lane-replicated store data.
- dmem_ack  in  1  memory completes the access this cycle.
- dmem_rdata  in  DATA_LENGTH  read word; valid with dmem_ack.
- ld_valid  out  1  one-cycle pulse: load data ready.
- ld_data  out  DATA_LENGTH  right-aligned load data; upper bits zero.
- ld_type  out  mem_type  type of the returned load.
- done  out  1  one-cycle pulse: any access (load or store) completed.
- misalign  out  1  one-cycle pulse: alignment exception.
- fault  out  1  one-cycle pulse: dmem timeout.
- bad_addr  out  DATA_LENGTH  address of the last misaligned or faulted request.

Behaviour:
- Reset: state IDLE, timeout counter 0. dmem_req, dmem_we, ld_valid, done, misalign and fault are 0. dmem_addr, dmem_be, dmem_wdata, ld_data and bad_addr are 0. ld_type is W. Reset is asynchronous: asserting it mid-access drops dmem_req immediately and discards the access.
- FSM states: IDLE, WAIT.
- Accept: a request is accepted when req_valid && req_ready are both high in IDLE.
- Alignment check on accept: H/HU need addr[0]==0; W needs addr[1:0]==0; B/BU are always aligned.
  - Misaligned: no memory access. Next cycle misalign=1 and bad_addr=req_addr. Stay in IDLE.
- Aligned accept: register dmem_* outputs and go to WAIT. dmem_req=1 from the next cycle.
- Byte enables: B/BU = 4'b0001<<addr[1:0]; H/HU = 4'b0011<<addr[1:0]; W = 4'b1111.
- Store data: B/BU = {4{wdata[7:0]}}; H/HU = {2{wdata[15:0]}}; W = wdata. BU/HU stores behave as B/H.
- WAIT: dmem_req and all dmem_* outputs are held stable until dmem_ack.
  - Ack may arrive in the first WAIT cycle.
  - On ack: go to IDLE and pulse done next cycle.
  - For loads on ack: ld_data = (dmem_rdata >> 8*addr[1:0]) masked to 8 bits (B/BU), 16 bits (H/HU) or 32 bits (W); ld_type = request type; ld_valid pulses with done.
  - ld_data and ld_type hold until the next load completes.
- Timeout: counter clears on entering WAIT and increments each WAIT cycle without ack. When it equals TIMEOUT_CYC with no ack that cycle: dmem_req drops next cycle, fault=1, bad_addr=address, go to IDLE. An ack in the same cycle as the timeout takes priority (normal completion).
- dmem_ack while in IDLE is ignored.
- Minimum access latency: accept at cycle N, dmem_req at N+1, ack at N+1, done/ld_valid at N+2. req_ready is high again at N+2, so back-to-back accepts are spaced 2 cycles apart.
- dmem_we=0 and dmem_wdata=0 for loads.

Test Plan:
- LB, addr=0x1003, ack on first WAIT cycle, rdata=0x80AABBCC -> dmem_addr=0x1000, be=4'b1000; ld_data=0x00000080, ld_type=B, ld_valid at N+2.
- SH, addr=0x2002, wdata=0x1234ABCD -> dmem_we=1, be=4'b1100, dmem_wdata=0xABCDABCD; done at N+2; no ld_valid.
- LW, addr=0x3001 -> no dmem_req; misalign=1 one cycle later; bad_addr=0x3001; req_ready stays 1.
- LHU, addr=0x4002, ack delayed 5 cycles, rdata=0xFEDC0000 -> dmem_req high for 6 cycles with stable addr/be; ld_data=0x0000FEDC.
- TIMEOUT_CYC=4, LW to 0x5000, no ack -> fault pulse, dmem_req deasserted, bad_addr=0x5000, back to IDLE. Repeat with ack on the timeout cycle -> done, no fault.
- rst_n low during WAIT -> dmem_req=0 immediately. After release, req_ready=1 and no done/ld_valid pulse is produced for the aborted access.
